// File: rtl/bcd_seg_scan.sv
// Three-digit multiplexed 7-segment driver fed by packed BCD.
// New values are committed only at frame boundaries, so the display never tears.
module bcd_seg_scan #(
  parameter int DIV_MAX        = 50000,
  parameter int DIV_W          = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_LZ       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bcd_in,
  input  logic        bcd_vld,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  an,
  output logic        upd
);

  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_digit;
  logic [11:0]      r_shown;
  logic [11:0]      r_pend;
  logic             r_pend_flag;
  logic [6:0]       r_seg;
  logic [2:0]       r_an;
  logic             r_upd;

  logic             w_tick;
  logic [1:0]       w_digit_next;
  logic             w_commit;
  logic [11:0]      w_shown_next;
  logic [3:0]       w_nib;
  logic             w_blank;
  logic [6:0]       w_pat;
  logic [6:0]       w_seg_next;

  assign w_tick       = (r_div_cnt == DIV_W'(DIV_MAX - 1));
  assign w_digit_next = (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
  assign w_commit     = w_tick && (r_digit == 2'd2) && r_pend_flag;
  assign w_shown_next = w_commit ? r_pend : r_shown;

  // The ones digit decoded on a boundary tick must already see the committed value.
  always_comb begin
    w_nib   = 4'h0;
    w_blank = 1'b0;
    case (w_digit_next)
      2'd0:    w_nib = w_shown_next[3:0];
      2'd1:    w_nib = w_shown_next[7:4];
      default: w_nib = w_shown_next[11:8];
    endcase
    if (BLANK_LZ != 0) begin
      if (w_digit_next == 2'd2)
        w_blank = (w_shown_next[11:8] == 4'h0);
      else if (w_digit_next == 2'd1)
        w_blank = (w_shown_next[11:4] == 8'h00);
    end
  end

  always_comb begin
    w_pat = 7'h40;
    case (w_nib)
      4'd0:    w_pat = 7'h3F;
      4'd1:    w_pat = 7'h06;
      4'd2:    w_pat = 7'h5B;
      4'd3:    w_pat = 7'h4F;
      4'd4:    w_pat = 7'h66;
      4'd5:    w_pat = 7'h6D;
      4'd6:    w_pat = 7'h7D;
      4'd7:    w_pat = 7'h07;
      4'd8:    w_pat = 7'h7F;
      4'd9:    w_pat = 7'h6F;
      default: w_pat = 7'h40;
    endcase
  end

  assign w_seg_next = w_blank ? SEG_OFF :
                      ((SEG_ACTIVE_LOW != 0) ? ~w_pat : w_pat);

  // r_digit holds the digit currently driven; resetting it to hundreds makes the
  // first tick after reset start a fresh frame on the ones digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt   <= '0;
      r_digit     <= 2'd2;
      r_shown     <= 12'h000;
      r_pend      <= 12'h000;
      r_pend_flag <= 1'b0;
      r_an        <= 3'b111;
      r_seg       <= SEG_OFF;
      r_upd       <= 1'b0;
    end else begin
      r_upd     <= 1'b0;
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      if (w_tick) begin
        r_digit <= w_digit_next;
        r_an    <= ~(3'b001 << w_digit_next);
        r_seg   <= w_seg_next;
      end
      if (w_commit) begin
        r_shown <= r_pend;
        r_upd   <= 1'b1;
      end
      if (bcd_vld) begin
        r_pend      <= bcd_in;
        r_pend_flag <= 1'b1;
      end else if (w_commit) begin
        r_pend_flag <= 1'b0;
      end
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign upd = r_upd;
  assign dp  = (SEG_ACTIVE_LOW != 0);

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan: a cycle-level reference model queues the expected
// outputs after every edge and an independent monitor compares them on the falling edge.
module tb_bcd_seg_scan;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] bcd_in;
  logic        bcd_vld;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  an;
  logic        upd;

  bcd_seg_scan #(.DIV_MAX(DIV), .DIV_W(16), .SEG_ACTIVE_LOW(1), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_vld(bcd_vld),
    .seg(seg), .dp(dp), .an(an), .upd(upd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] an;
    logic [6:0] seg;
    logic       upd;
  } exp_t;

  exp_t queueExp[$];
  int   checks = 0;
  int   passes = 0;
  int   cycle  = 0;

  // Reference state: edges since reset release, displayed and pending values.
  int          mCnt = 0;
  logic [11:0] mShown, mPend;
  bit          mFlag;
  logic [2:0]  mAn;
  logic [6:0]  mSeg;
  logic        mUpd;

  function automatic logic [6:0] render(input logic [11:0] val, input int digit);
    logic [6:0] font [10];
    int nib, hund, tens;
    logic [6:0] pat;
    font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    nib  = (int'(val) >> (4 * digit)) % 16;
    hund = int'(val) / 256;
    tens = (int'(val) / 16) % 16;
    if (digit == 2 && hund == 0) return 7'h7F;
    if (digit == 1 && hund == 0 && tens == 0) return 7'h7F;
    pat = (nib <= 9) ? font[nib] : 7'h40;
    return ~pat;
  endfunction

  // True when the coming rising edge is a tick that starts a new frame.
  function automatic bit nextIsBoundary();
    int n;
    n = mCnt + 1;
    return (n % DIV == 0) && (((n / DIV) - 1) % 3 == 0);
  endfunction

  always @(posedge clk) begin
    int k, digit;
    cycle++;
    if (rst) begin
      mCnt = 0; mShown = 12'h000; mPend = 12'h000; mFlag = 0;
      mAn = 3'b111; mSeg = 7'h7F; mUpd = 1'b0;
    end else begin
      mCnt++;
      mUpd = 1'b0;
      if (mCnt % DIV == 0) begin
        k     = mCnt / DIV;
        digit = (k - 1) % 3;
        if (digit == 0 && mFlag) begin
          mShown = mPend; mFlag = 0; mUpd = 1'b1;
        end
        mAn  = ~(3'(1) << digit);
        mSeg = render(mShown, digit);
      end
      if (bcd_vld) begin
        mPend = bcd_in; mFlag = 1;
      end
    end
    queueExp.push_back('{an: mAn, seg: mSeg, upd: mUpd});
  end

  task automatic checkOutput(input exp_t e);
    checks++;
    if (an === e.an && seg === e.seg && upd === e.upd && dp === 1'b1) begin
      passes++;
    end else begin
      $display("[TB] FAIL cyc%0d outputs: got an=%b seg=%h upd=%b dp=%b, expected an=%b seg=%h upd=%b dp=1",
               cycle, an, seg, upd, dp, e.an, e.seg, e.upd);
    end
  endtask

  // Monitor: every edge presents a new output word, compared half a cycle later.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (queueExp.size() == 0) begin
        checks++;
        $display("[TB] FAIL cyc%0d scoreboard: got empty queue, expected an entry", cycle);
      end else begin
        checkOutput(queueExp.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [11:0] v);
    bcd_in = v; bcd_vld = 1'b1;
    @(negedge clk);
    bcd_vld = 1'b0;
  endtask

  task automatic waitBoundary();
    int guard;
    guard = 0;
    while (!nextIsBoundary() && guard < 100) begin
      @(negedge clk);
      guard++;
    end
  endtask

  function automatic logic [3:0] randNib();
    return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
  endfunction

  initial begin
    logic [11:0] v;
    rst = 1'b1; bcd_vld = 1'b0; bcd_in = 12'h000;
    idle(3);
    rst = 1'b0;
    idle(30);

    applyStimulus(12'h123); idle(40);
    applyStimulus(12'h007); idle(30);
    applyStimulus(12'h100); idle(30);
    applyStimulus(12'h0A5); idle(30);

    waitBoundary(); idle(2);
    applyStimulus(12'h111); idle(2);
    applyStimulus(12'h222);
    waitBoundary();
    applyStimulus(12'h333);
    idle(40);

    waitBoundary(); idle(2);
    applyStimulus(12'h456);
    waitBoundary();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(30);

    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      bcd_vld = ($urandom_range(0, 7) == 0);
      v = {randNib(), randNib(), randNib()};
      if ($urandom_range(0, 2) == 0) v[11:8] = 4'h0;
      if ($urandom_range(0, 3) == 0) v[7:4]  = 4'h0;
      bcd_in = v;
      @(negedge clk);
    end
    rst = 1'b0; bcd_vld = 1'b0;
    idle(20);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
